reorder_buffer: RTL and testbench

//  Circular in-order retirement queue for the out-of-order core. Allocates a tag per issued instr,

---
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 tb/tb_reorder_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates tags at issue, collects CDB results, retires the head in order.
// Optional build macro ROB_WB_BYPASS_EN lets the head retire in the same cycle its result arrives on the CDB.
module reorder_buffer #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic                    issue_has_rd,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_is_br,
    input  logic                    issue_pred_tk,
    input  logic [31:0]             issue_alt_pc,
    output logic                    issue_ready,
    output logic [ROB_SIZE_BIT-1:0] issue_tag,
    input  logic                    wb_valid,
    input  logic [ROB_SIZE_BIT-1:0] wb_tag,
    input  logic [31:0]             wb_val,
    input  logic                    wb_br_tk,
    output logic                    rf_dep_en,
    output logic [4:0]              rf_dep_id,
    output logic [ROB_SIZE_BIT-1:0] rf_dep_dep,
    output logic                    rf_val_en,
    output logic [4:0]              rf_val_id,
    output logic [ROB_SIZE_BIT-1:0] rf_val_dep,
    output logic [31:0]             rf_val_val,
    output logic                    rob_clear,
    output logic [31:0]             flush_pc,
    output logic [ROB_SIZE_BIT:0]   rob_count
);

    localparam int DEPTH = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0]   FULL_CNT = DEPTH[ROB_SIZE_BIT:0];
    localparam logic [ROB_SIZE_BIT-1:0] TAG_ONE  = 1;
    localparam logic [ROB_SIZE_BIT:0]   CNT_ONE  = 1;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_ready;
    logic [DEPTH-1:0] e_has_rd;
    logic [DEPTH-1:0] e_is_br;
    logic [DEPTH-1:0] e_pred_tk;
    logic [DEPTH-1:0] e_act_tk;
    logic [4:0]       e_rd     [DEPTH];
    logic [31:0]      e_alt_pc [DEPTH];
    logic [31:0]      e_val    [DEPTH];

    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;
    logic [ROB_SIZE_BIT:0]   count;

    logic        head_ready;
    logic        head_act_tk;
    logic [31:0] head_val;
    logic        commit;
    logic        mispred;
    logic        issue;

`ifdef ROB_WB_BYPASS_EN
    logic wb_hit_head;
    always_comb begin
        wb_hit_head = wb_valid & (wb_tag == head);
        head_ready  = e_ready[head] | wb_hit_head;
        head_act_tk = wb_hit_head ? wb_br_tk : e_act_tk[head];
        head_val    = wb_hit_head ? wb_val : e_val[head];
    end
`else
    always_comb begin
        head_ready  = e_ready[head];
        head_act_tk = e_act_tk[head];
        head_val    = e_val[head];
    end
`endif

    always_comb begin
        commit      = rdy_in & e_valid[head] & head_ready;
        mispred     = commit & e_is_br[head] & (e_pred_tk[head] != head_act_tk);
        // A full queue still accepts when the head retires this cycle, but never during a flush.
        issue_ready = ~mispred & ((count < FULL_CNT) | commit);
        issue       = rdy_in & issue_valid & issue_ready;

        issue_tag   = tail;
        rf_dep_en   = issue & issue_has_rd;
        rf_dep_id   = issue_rd;
        rf_dep_dep  = tail;

        rf_val_en   = commit & e_has_rd[head];
        rf_val_id   = e_rd[head];
        rf_val_dep  = head;
        rf_val_val  = head_val;
        rob_clear   = mispred;
        flush_pc    = mispred ? e_alt_pc[head] : 32'h0;
        rob_count   = count;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            e_valid   <= '0;
            e_ready   <= '0;
            e_has_rd  <= '0;
            e_is_br   <= '0;
            e_pred_tk <= '0;
            e_act_tk  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_rd[i]     <= '0;
                e_alt_pc[i] <= '0;
                e_val[i]    <= '0;
            end
        end else if (rdy_in) begin
            if (mispred) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                e_valid <= '0;
                e_ready <= '0;
            end else begin
                if (wb_valid && e_valid[wb_tag]) begin
                    e_val[wb_tag]    <= wb_val;
                    e_act_tk[wb_tag] <= wb_br_tk;
                    e_ready[wb_tag]  <= 1'b1;
                end
                if (commit) begin
                    e_valid[head] <= 1'b0;
                    e_ready[head] <= 1'b0;
                    head          <= head + TAG_ONE;
                end
                // Issue last: when full, tail == head and the new entry must win over the retire.
                if (issue) begin
                    e_valid[tail]   <= 1'b1;
                    e_ready[tail]   <= 1'b0;
                    e_has_rd[tail]  <= issue_has_rd;
                    e_rd[tail]      <= issue_rd;
                    e_is_br[tail]   <= issue_is_br;
                    e_pred_tk[tail] <= issue_pred_tk;
                    e_alt_pc[tail]  <= issue_alt_pc;
                    tail            <= tail + TAG_ONE;
                end
                if (issue && !commit)
                    count <= count + CNT_ONE;
                else if (commit && !issue)
                    count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; expectations follow ROB_WB_BYPASS_EN when defined.
module tb_reorder_buffer;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_is_br;
    logic        issue_pred_tk;
    logic [31:0] issue_alt_pc;
    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_val;
    logic        wb_br_tk;
    logic        rf_dep_en;
    logic [4:0]  rf_dep_id;
    logic [2:0]  rf_dep_dep;
    logic        rf_val_en;
    logic [4:0]  rf_val_id;
    logic [2:0]  rf_val_dep;
    logic [31:0] rf_val_val;
    logic        rob_clear;
    logic [31:0] flush_pc;
    logic [3:0]  rob_count;

    int n_assert = 0;
    int n_fail   = 0;

    reorder_buffer #(.ROB_SIZE_BIT(3)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_is_br(issue_is_br), .issue_pred_tk(issue_pred_tk), .issue_alt_pc(issue_alt_pc),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_br_tk(wb_br_tk),
        .rf_dep_en(rf_dep_en), .rf_dep_id(rf_dep_id), .rf_dep_dep(rf_dep_dep),
        .rf_val_en(rf_val_en), .rf_val_id(rf_val_id), .rf_val_dep(rf_val_dep), .rf_val_val(rf_val_val),
        .rob_clear(rob_clear), .flush_pc(flush_pc), .rob_count(rob_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_has_rd = 0; issue_rd = 0; issue_is_br = 0;
        issue_pred_tk = 0; issue_alt_pc = 0;
        wb_valid = 0; wb_tag = 0; wb_val = 0; wb_br_tk = 0;
    endtask

    // inputs change 1 time unit after the rising edge; checks run 1 unit later
    task automatic cyc();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic has_rd);
        issue_valid = 1; issue_has_rd = has_rd; issue_rd = rd;
    endtask

    task automatic do_wb(input logic [2:0] tag, input logic [31:0] val, input logic tk);
        wb_valid = 1; wb_tag = tag; wb_val = val; wb_br_tk = tk;
    endtask

    task automatic do_reset();
        rst_n_in = 0; rdy_in = 1; idle();
        #3;
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_issue_tag", 32'(issue_tag), 0);
        chk("rst_rob_count", 32'(rob_count), 0);
        chk("rst_rf_val_en", 32'(rf_val_en), 0);
        chk("rst_rf_dep_en", 32'(rf_dep_en), 0);
        chk("rst_rob_clear", 32'(rob_clear), 0);
        chk("rst_flush_pc", flush_pc, 0);
        @(negedge clk_in);
        rst_n_in = 1;
        cyc();
    endtask

    initial begin
        // Test 1: single issue, writeback, retire
        do_reset();
        do_issue(5, 1); settle();
        chk("t1_issue_tag", 32'(issue_tag), 0);
        chk("t1_dep_en", 32'(rf_dep_en), 1);
        chk("t1_dep_id", 32'(rf_dep_id), 5);
        chk("t1_dep_dep", 32'(rf_dep_dep), 0);
        cyc();
        do_wb(0, 32'h1234, 0); settle();
        chk("t1_count_wb", 32'(rob_count), 1);
        chk("t1_val_en_wb_cycle", 32'(rf_val_en), 32'(BYP));
        if (BYP) chk("t1_byp_val", rf_val_val, 32'h1234);
        cyc();
        if (!BYP) begin
            settle();
            chk("t1_val_en", 32'(rf_val_en), 1);
            chk("t1_val_id", 32'(rf_val_id), 5);
            chk("t1_val_dep", 32'(rf_val_dep), 0);
            chk("t1_val_val", rf_val_val, 32'h1234);
            chk("t1_count_commit", 32'(rob_count), 1);
            cyc();
        end
        chk("t1_count_after", 32'(rob_count), 0);
        chk("t1_val_en_after", 32'(rf_val_en), 0);

        // Test 2: out-of-order writeback, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_issue(5'(i + 1), 1); settle();
            chk("t2_issue_tag", 32'(issue_tag), 32'(i));
            cyc();
        end
        do_wb(2, 32'h22, 0); settle();
        chk("t2_no_ret_wb2", 32'(rf_val_en), 0);
        cyc();
        do_wb(1, 32'h11, 0); settle();
        chk("t2_no_ret_wb1", 32'(rf_val_en), 0);
        cyc();
        do_wb(0, 32'h00, 0); settle();
        chk("t2_ret_wb0", 32'(rf_val_en), 32'(BYP));
        if (BYP) chk("t2_ret_id1", 32'(rf_val_id), 1);
        cyc();
        if (!BYP) begin
            settle();
            chk("t2_ret_en1", 32'(rf_val_en), 1);
            chk("t2_ret_id1", 32'(rf_val_id), 1);
            chk("t2_ret_dep0", 32'(rf_val_dep), 0);
            cyc();
        end
        chk("t2_ret_en2", 32'(rf_val_en), 1);
        chk("t2_ret_id2", 32'(rf_val_id), 2);
        chk("t2_ret_val2", rf_val_val, 32'h11);
        cyc();
        chk("t2_ret_en3", 32'(rf_val_en), 1);
        chk("t2_ret_id3", 32'(rf_val_id), 3);
        chk("t2_ret_dep2", 32'(rf_val_dep), 2);
        cyc();
        chk("t2_empty_en", 32'(rf_val_en), 0);
        chk("t2_empty_count", 32'(rob_count), 0);

        // Test 3: fill to capacity, then push while the head pops
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_issue(5'(i + 1), 1);
            cyc();
        end
        chk("t3_full_count", 32'(rob_count), 8);
        chk("t3_full_ready", 32'(issue_ready), 0);
        do_issue(9, 1); do_wb(0, 32'hAA, 0); settle();
        chk("t3_wb_ready", 32'(issue_ready), 32'(BYP));
        chk("t3_wb_dep_en", 32'(rf_dep_en), 32'(BYP));
        if (!BYP) begin
            cyc();
            do_issue(9, 1); settle();
        end
        chk("t3_pop_val_en", 32'(rf_val_en), 1);
        chk("t3_pop_val_id", 32'(rf_val_id), 1);
        chk("t3_push_ready", 32'(issue_ready), 1);
        chk("t3_push_tag", 32'(issue_tag), 0);
        chk("t3_push_dep_en", 32'(rf_dep_en), 1);
        cyc();
        chk("t3_count_stays", 32'(rob_count), 8);
        chk("t3_next_tag", 32'(issue_tag), 1);
        chk("t3_full_again", 32'(issue_ready), 0);

        // Test 4: mispredicted branch flushes the queue
        do_reset();
        do_issue(7, 1); cyc();
        do_issue(0, 0); issue_is_br = 1; issue_pred_tk = 0; issue_alt_pc = 32'h80; cyc();
        do_issue(8, 1); cyc();
        do_wb(1, 32'h0, 1); settle();
        chk("t4_no_commit", 32'(rf_val_en), 0);
        cyc();
        do_wb(0, 32'h55, 0); settle();
        chk("t4_c0_wb_cycle", 32'(rf_val_en), 32'(BYP));
        cyc();
        if (!BYP) begin
            settle();
            chk("t4_c0_en", 32'(rf_val_en), 1);
            chk("t4_c0_id", 32'(rf_val_id), 7);
            chk("t4_c0_no_clear", 32'(rob_clear), 0);
            cyc();
        end
        do_issue(9, 1); settle();
        chk("t4_clear", 32'(rob_clear), 1);
        chk("t4_flush_pc", flush_pc, 32'h80);
        chk("t4_issue_blocked", 32'(issue_ready), 0);
        chk("t4_dep_dropped", 32'(rf_dep_en), 0);
        chk("t4_br_no_val", 32'(rf_val_en), 0);
        cyc();
        chk("t4_count_zero", 32'(rob_count), 0);
        chk("t4_tag_zero", 32'(issue_tag), 0);
        chk("t4_clear_gone", 32'(rob_clear), 0);
        chk("t4_flush_pc_zero", flush_pc, 0);
        chk("t4_ready_back", 32'(issue_ready), 1);

        // Test 5: rdy_in low freezes a ready head
        do_reset();
        do_issue(4, 1); cyc();
        do_issue(6, 1); cyc();
        do_wb(1, 32'hABCD, 0); cyc();
        do_wb(0, 32'h44, 0); settle();
        chk("t5_wb0_cycle", 32'(rf_val_en), 32'(BYP));
        cyc();
        if (!BYP) begin
            settle();
            chk("t5_c0_id", 32'(rf_val_id), 4);
            cyc();
        end
        chk("t5_head_count", 32'(rob_count), 1);
        for (int i = 0; i < 3; i++) begin
            rdy_in = 0; do_issue(3, 1); settle();
            chk("t5_frz_val_en", 32'(rf_val_en), 0);
            chk("t5_frz_dep_en", 32'(rf_dep_en), 0);
            cyc();
            chk("t5_frz_count", 32'(rob_count), 1);
        end
        rdy_in = 1; settle();
        chk("t5_resume_en", 32'(rf_val_en), 1);
        chk("t5_resume_id", 32'(rf_val_id), 6);
        chk("t5_resume_dep", 32'(rf_val_dep), 1);
        chk("t5_resume_val", rf_val_val, 32'hABCD);
        cyc();
        chk("t5_final_count", 32'(rob_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
